// File: rtl/bridge_tx.sv
// Bridge transmitter: turns each accepted memory read into a short ASCII
// message (preamble, four uppercase hex digits, optional CR/LF) and hands
// it byte by byte to a UART transmitter using a start/done handshake.
module bridge_tx #(
   parameter logic [7:0] PREAMBLE  = 8'h4D,
   parameter bit         SEND_CRLF = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] rdata_i,
   input  logic        rw_i,
   input  logic        valid_i,
   output logic [7:0]  data_o,
   output logic        start_o,
   input  logic        done_i,
   output logic        busy_o,
   output logic        dropped_o
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT
   } state_t;

   // Index of the final byte of a message: LF when CR/LF is appended,
   // otherwise the last hex digit.
   localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd6 : 3'd4;

   state_t      r_state;
   logic [2:0]  r_byteIdx;
   logic [15:0] r_latched;
   logic [7:0]  r_dataOut;
   logic        r_startOut;
   logic        r_busyOut;
   logic        r_dropped;

   logic        w_readStrobe;
   logic [2:0]  w_nextIdx;
   logic [7:0]  w_nextByte;

   // Uppercase ASCII for one nibble.
   function automatic logic [7:0] hexAscii(input logic [3:0] n);
      if (n < 4'd10) begin
         return 8'h30 + {4'h0, n};
      end
      return 8'h41 + {4'h0, n} - 8'd10;
   endfunction

   // Message byte at a given position for a latched word.
   function automatic logic [7:0] byteAt(input logic [2:0] idx, input logic [15:0] word);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = PREAMBLE;
         3'd1:    b = hexAscii(word[15:12]);
         3'd2:    b = hexAscii(word[11:8]);
         3'd3:    b = hexAscii(word[7:4]);
         3'd4:    b = hexAscii(word[3:0]);
         3'd5:    b = 8'h0D;
         3'd6:    b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign w_readStrobe = valid_i & ~rw_i;
   assign w_nextIdx    = r_byteIdx + 3'd1;
   assign w_nextByte   = byteAt(w_nextIdx, r_latched);

   // Message sequencer: accepts reads while idle, pulses start for each byte,
   // waits for the transmitter's done, and flags reads that arrive while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_byteIdx  <= 3'd0;
         r_latched  <= 16'h0000;
         r_dataOut  <= 8'h00;
         r_startOut <= 1'b0;
         r_busyOut  <= 1'b0;
         r_dropped  <= 1'b0;
      end else begin
         if (w_readStrobe && (r_state != IDLE)) begin
            r_dropped <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               r_startOut <= 1'b0;
               if (w_readStrobe) begin
                  r_latched  <= rdata_i;
                  r_byteIdx  <= 3'd0;
                  r_dataOut  <= PREAMBLE;
                  r_startOut <= 1'b1;
                  r_busyOut  <= 1'b1;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               r_startOut <= 1'b0;
               r_state    <= WAIT;
            end
            WAIT: begin
               if (done_i) begin
                  if (r_byteIdx == LAST_IDX) begin
                     r_byteIdx <= 3'd0;
                     r_busyOut <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     r_byteIdx  <= w_nextIdx;
                     r_dataOut  <= w_nextByte;
                     r_startOut <= 1'b1;
                     r_state    <= SEND;
                  end
               end
            end
            default: begin
               r_startOut <= 1'b0;
               r_busyOut  <= 1'b0;
               r_byteIdx  <= 3'd0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign data_o    = r_dataOut;
   assign start_o   = r_startOut;
   assign busy_o    = r_busyOut;
   assign dropped_o = r_dropped;

endmodule

// File: doc/bridge_tx.md
BRIDGE_TX -- requirements
Module: bridge_tx

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter PREAMBLE, default 8'h4D ('M'), SHALL be the first byte of every response message.
REQ-003 Parameter SEND_CRLF, default 1, SHALL append 8'h0D, 8'h0A to each message when 1 and omit them when 0.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port rdata_i  input  16  read data from the tail of the memory bus chain.
REQ-007 Port rw_i  input  1  bus transaction type from the chain tail; 0=read, 1=write.
REQ-008 Port valid_i  input  1  single-cycle strobe qualifying rdata_i/rw_i; no backpressure exists.
REQ-009 Port data_o  output  8  byte presented to the UART transmitter.
REQ-010 Port start_o  output  1  one-cycle pulse requesting transmission of data_o.
REQ-011 Port done_i  input  1  one-cycle pulse from the UART transmitter when the byte finishes.
REQ-012 Port busy_o  output  1  high while a message is in progress.
REQ-013 Port dropped_o  output  1  sticky flag, set when a read response arrives while busy.

Function
REQ-014 A read is accepted when valid_i=1, rw_i=0 and busy_o=0; rdata_i SHALL be latched in that cycle.
REQ-015 valid_i with rw_i=1 SHALL be ignored (no message, no flag change).
REQ-016 Message SHALL be: PREAMBLE, four ASCII hex digits of the latched word MSB nibble first, then CR, LF if SEND_CRLF=1 (7 bytes, or 5 if 0).
REQ-017 Hex encoding SHALL be uppercase: nibble 0-9 -> 8'h30+n, A-F -> 8'h41+(n-10).
REQ-018 States SHALL be IDLE, SEND, WAIT; IDLE->SEND on accept; SEND->WAIT unconditionally after one cycle; WAIT->SEND on done_i if bytes remain, WAIT->IDLE on done_i after the last byte.
REQ-019 start_o SHALL be 1 only in SEND; first start_o SHALL assert the cycle after accept.
REQ-020 data_o SHALL be valid in SEND and held stable through WAIT until done_i is sampled.
REQ-021 done_i SHALL be ignored outside WAIT, including in the SEND cycle.
REQ-022 A byte index counter (3 bits) SHALL advance only on done_i in WAIT and clear on return to IDLE.
REQ-023 busy_o SHALL be 1 in SEND and WAIT, 0 in IDLE; a read in the cycle busy_o returns to 0 SHALL be accepted.
REQ-024 A read strobe (rw_i=0, valid_i=1) while busy_o=1 SHALL be discarded and SHALL set dropped_o the next cycle; the message in flight SHALL be unaffected.
REQ-025 dropped_o SHALL clear only on reset.
REQ-026 Latched data SHALL not change for the rest of the message regardless of rdata_i.

Reset
REQ-027 While rst=1: state=IDLE, byte index=0, latched data=0, data_o=8'h00, start_o=0, busy_o=0, dropped_o=0.
REQ-028 Reset asserted mid-message SHALL abort it; no further start_o until a new accepted read after rst deasserts.
REQ-029 valid_i in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-030 Read rdata_i=16'h0012, done_i returned 3 cycles after each start_o -> bytes 4D,30,30,31,32,0D,0A, seven start_o pulses, busy_o low after last done_i.
REQ-031 Read rdata_i=16'hBEEF with SEND_CRLF=0 -> bytes 4D,42,45,45,46, five pulses, no CR/LF.
REQ-032 Write strobe rw_i=1, rdata_i=16'h0069 -> no start_o, busy_o stays 0, dropped_o stays 0.
REQ-033 Second read 16'h000A issued during message for 16'h0001 -> first message completes as 4D,30,30,30,31,0D,0A; dropped_o=1; no second message.
REQ-034 rst pulsed after third done_i of 16'h1234 message -> all outputs reset values; next read 16'h0007 yields 4D,30,30,30,37,0D,0A.
REQ-035 done_i asserted during SEND cycle and while IDLE -> ignored; byte sequence and count unchanged.
